// File: rtl/mod_uart_rx_fifo.sv
// UART receiver (8N1, 16x oversampling) with a 16-entry receive FIFO,
// exposed to the CPU as four memory-mapped registers selected by daddr[3:2]:
//   0 STATUS (ro)  1 DATA (ro, pops)  2 CMD (wo)  3 IE (rw)
// int_rx is a registered level interrupt raised while data or an error
// flag is pending and the interrupt is enabled.
`timescale 1ns/1ps

module mod_uart_rx_fifo #(
    parameter int BAUD_DIV   = 27,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        de,
    input  logic [31:0] daddr,
    input  logic [1:0]  drw,
    input  logic [31:0] din,
    output logic [31:0] dout,
    input  logic        rxd,
    output logic        int_rx
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } rx_state_t;

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    logic [15:0]   tick_cnt;
    logic          tick;

    logic          rx_meta;
    logic          rxs;

    rx_state_t     state, state_next;
    logic [3:0]    samp_cnt, samp_cnt_next;
    logic [2:0]    bit_cnt, bit_cnt_next;
    logic [7:0]    shift_reg, shift_next;
    logic          push_req;
    logic          frame_err;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wptr, rptr;
    logic [CW-1:0] count;
    logic          empty, full;
    logic          push_ok;
    logic          ovr_set;

    logic          overrun, framing, ie;

    logic          rd_acc, wr_acc;
    logic [1:0]    sel;
    logic          pop;
    logic          cmd_wr;
    logic          flush;
    logic          ie_wr;

    // Address and data bits the register map does not decode.
    logic          unused_bits;
    assign unused_bits = &{1'b0, daddr[31:4], daddr[1:0], din[31:3]};

    // ------------------------------------------------------------------
    // Oversample tick: free-running divider, one-cycle pulse at wrap
    // ------------------------------------------------------------------
    assign tick = (tick_cnt == 16'(BAUD_DIV - 1));

    // Divider counter wraps at BAUD_DIV-1.
    // NOTE: state registers use non-blocking (<=) so every flop samples
    // the pre-edge value of its neighbours, exactly like the hardware.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 16'd1;
        end
    end

    // Two-flop synchroniser for the asynchronous serial input (idle high).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rxd;
            rxs     <= rx_meta;
        end
    end

    // ------------------------------------------------------------------
    // Receiver FSM
    // ------------------------------------------------------------------
    // Receiver state register and bit-timing counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            samp_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
        end else begin
            state     <= state_next;
            samp_cnt  <= samp_cnt_next;
            bit_cnt   <= bit_cnt_next;
            shift_reg <= shift_next;
        end
    end

    // Next-state logic: mid-bit sampling at tick 8 of the start bit, then
    // every 16 ticks for the data and stop bits.
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_next    = state;
        samp_cnt_next = samp_cnt;
        bit_cnt_next  = bit_cnt;
        shift_next    = shift_reg;
        push_req      = 1'b0;
        frame_err     = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (!rxs) begin
                    samp_cnt_next = '0;
                    state_next    = S_START;
                end
            end
            S_START: begin
                if (tick) begin
                    if (samp_cnt == 4'd7) begin
                        samp_cnt_next = '0;
                        bit_cnt_next  = '0;
                        // A high level at mid start bit is a glitch.
                        state_next    = rxs ? S_IDLE : S_DATA;
                    end else begin
                        samp_cnt_next = samp_cnt + 4'd1;
                    end
                end
            end
            S_DATA: begin
                if (tick) begin
                    if (samp_cnt == 4'd15) begin
                        samp_cnt_next = '0;
                        shift_next    = {rxs, shift_reg[7:1]};
                        bit_cnt_next  = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state_next = S_STOP;
                        end
                    end else begin
                        samp_cnt_next = samp_cnt + 4'd1;
                    end
                end
            end
            S_STOP: begin
                if (tick) begin
                    if (samp_cnt == 4'd15) begin
                        samp_cnt_next = '0;
                        if (rxs) begin
                            push_req   = 1'b1;
                            state_next = S_IDLE;
                        end else begin
                            frame_err  = 1'b1;
                            state_next = S_WAIT_HIGH;
                        end
                    end else begin
                        samp_cnt_next = samp_cnt + 4'd1;
                    end
                end
            end
            S_WAIT_HIGH: begin
                // Hold off until the line returns high so a break is not
                // re-read as a stream of frames.
                if (rxs) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    assign rd_acc = de & (drw == 2'b10);
    assign wr_acc = de & (drw == 2'b01);
    assign sel    = daddr[3:2];

    assign empty  = (count == '0);
    assign full   = (count == CW'(FIFO_DEPTH));

    assign pop    = rd_acc & (sel == 2'd1) & ~empty;
    assign cmd_wr = wr_acc & (sel == 2'd2);
    assign flush  = cmd_wr & din[2];
    assign ie_wr  = wr_acc & (sel == 2'd3);

    // A same-cycle pop frees a slot even when full; flush discards the byte.
    assign push_ok = push_req & ~flush & (~full | pop);
    assign ovr_set = push_req & ~flush & full & ~pop;

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    // Storage array written on each accepted byte.
    // NOTE: the data array has no reset; pointers and count define which
    // entries are valid, so clearing the contents would buy nothing.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wptr] <= shift_reg;
        end
    end

    // Pointers and occupancy; flush returns everything to empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push_ok) begin
                wptr <= wptr + PW'(1);
            end
            if (pop) begin
                rptr <= rptr + PW'(1);
            end
            unique case ({push_ok, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Flags, interrupt enable and interrupt
    // ------------------------------------------------------------------
    // Sticky error flags: a new event in the clearing cycle keeps the flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun <= 1'b0;
            framing <= 1'b0;
        end else begin
            overrun <= ovr_set   | (overrun & ~(cmd_wr & din[0]));
            framing <= frame_err | (framing & ~(cmd_wr & din[1]));
        end
    end

    // Interrupt-enable register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ie <= 1'b0;
        end else if (ie_wr) begin
            ie <= din[0];
        end
    end

    // Level interrupt, one cycle behind the state it reflects.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            int_rx <= 1'b0;
        end else begin
            int_rx <= ie & (~empty | overrun | framing);
        end
    end

    // Read mux: combinational from registered state, zero when not reading.
    always_comb begin
        dout = '0;
        if (rd_acc) begin
            unique case (sel)
                2'd0: begin
                    dout[0]   = ~empty;
                    dout[1]   = full;
                    dout[2]   = overrun;
                    dout[3]   = framing;
                    dout[8:4] = 5'(count);
                end
                2'd1: begin
                    if (!empty) begin
                        dout[7:0] = mem[rptr];
                    end
                end
                2'd3: begin
                    dout[0] = ie;
                end
                default: begin
                    dout = '0;
                end
            endcase
        end
    end

endmodule
